// File: rtl/spatial_fold_encoder_pkg.sv
// Shared constants for the spatial fold encoder: modality codes, channel counts,
// counter widths and the majority threshold helper.
package spatial_fold_encoder_pkg;

  localparam int HV_DIMENSION          = 2000;
  localparam int GSR_NUM_CHANNEL       = 32;
  localparam int ECG_NUM_CHANNEL       = 77;
  localparam int EEG_NUM_CHANNEL       = 105;
  localparam int MAX_NUM_CHANNEL       = 105;
  // Beat counter must be able to hold N itself, since beat_cnt == N marks the delimiter.
  localparam int MAX_NUM_CHANNEL_WIDTH = $clog2(MAX_NUM_CHANNEL + 1);
  localparam int CNT_W                 = $clog2(MAX_NUM_CHANNEL + 1);

  typedef enum logic [1:0] {
    MOD_GSR = 2'd0,
    MOD_ECG = 2'd1,
    MOD_EEG = 2'd2
  } modality_e;

  function automatic logic [MAX_NUM_CHANNEL_WIDTH-1:0] num_channel(input modality_e m);
    case (m)
      MOD_ECG: num_channel = MAX_NUM_CHANNEL_WIDTH'(ECG_NUM_CHANNEL);
      MOD_EEG: num_channel = MAX_NUM_CHANNEL_WIDTH'(EEG_NUM_CHANNEL);
      default: num_channel = MAX_NUM_CHANNEL_WIDTH'(GSR_NUM_CHANNEL);
    endcase
  endfunction

  // 2*count > N  <=>  count > floor(N/2); even-N ties therefore give 0.
  function automatic logic [CNT_W-1:0] majority_threshold(input logic [MAX_NUM_CHANNEL_WIDTH-1:0] n);
    majority_threshold = CNT_W'(n >> 1);
  endfunction

endpackage

// File: rtl/spatial_fold_encoder_bit_accumulator.sv
// One per-bit popcount across a fold's channel beats, with majority compare.
module spatial_fold_encoder_bit_accumulator
  import spatial_fold_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             above
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign above = count > thr;

endmodule

// File: rtl/spatial_fold_encoder.sv
// Binds im/projm beats, accumulates per-bit popcounts per (modality, fold) and
// emits a majority slice through a single-entry output register.
module spatial_fold_encoder
  import spatial_fold_encoder_pkg::*;
#(
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int FOLD_WIDTH      = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [FOLD_WIDTH-1:0]      im_in,
  input  logic [FOLD_WIDTH-1:0]      projm_in,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FOLD_WIDTH-1:0]      dout,
  output logic [1:0]                 dout_modality,
  output logic [NUM_FOLDS_WIDTH-1:0] dout_fold,
  output logic                       dout_last
);

  modality_e                        state, state_nxt;
  logic [MAX_NUM_CHANNEL_WIDTH-1:0] n_ch;
  logic [MAX_NUM_CHANNEL_WIDTH-1:0] beat_cnt;
  logic [CNT_W-1:0]                 thr;
  logic [NUM_FOLDS_WIDTH-1:0]       fold_cnt;
  logic                             fire, is_delim, data_fire, delim_fire, last_fold;
  logic [FOLD_WIDTH-1:0]            xor_bits, maj;

  assign din_ready  = !dout_valid || dout_ready;
  assign fire       = din_valid && din_ready;
  assign is_delim   = beat_cnt == n_ch;
  assign data_fire  = fire && !is_delim;
  assign delim_fire = fire && is_delim;
  assign last_fold  = fold_cnt == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  assign xor_bits   = im_in ^ projm_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MOD_GSR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (delim_fire && last_fold) begin
      case (state)
        MOD_GSR: state_nxt = MOD_ECG;
        MOD_ECG: state_nxt = MOD_EEG;
        default: state_nxt = MOD_GSR;
      endcase
    end
  end

  always_comb begin
    n_ch = num_channel(state);
    thr  = majority_threshold(n_ch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      fold_cnt <= '0;
    end else if (delim_fire) begin
      beat_cnt <= '0;
      fold_cnt <= last_fold ? '0 : fold_cnt + 1'b1;
    end else if (data_fire) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Counts are compared before the delimiter clears them, so the slice never sees it.
  for (genvar i = 0; i < FOLD_WIDTH; i++) begin : g_acc
    spatial_fold_encoder_bit_accumulator u_acc (
      .clk   (clk),
      .rst   (rst),
      .inc   (data_fire && xor_bits[i]),
      .clr   (delim_fire),
      .thr   (thr),
      .above (maj[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid    <= 1'b0;
      dout          <= '0;
      dout_modality <= 2'd0;
      dout_fold     <= '0;
      dout_last     <= 1'b0;
    end else if (delim_fire) begin
      dout_valid    <= 1'b1;
      dout          <= maj;
      dout_modality <= state;
      dout_fold     <= fold_cnt;
      dout_last     <= (state == MOD_EEG) && last_fold;
    end else if (dout_valid && dout_ready) begin
      dout_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spatial_fold_encoder.sv
// Scoreboard bench for spatial_fold_encoder: directed threshold vectors plus
// random-data streams, with stalls, gaps and a mid-stream reset.
module tb_spatial_fold_encoder;

  localparam int NF  = 4;
  localparam int NFW = 2;
  localparam int FW  = 500;

  typedef struct {
    logic [FW-1:0]  dat;
    logic [1:0]     mod;
    logic [NFW-1:0] fold;
    logic           last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [FW-1:0]  im_in = '0;
  logic [FW-1:0]  projm_in = '0;
  logic           dout_valid;
  logic           dout_ready = 1'b1;
  logic [FW-1:0]  dout;
  logic [1:0]     dout_modality;
  logic [NFW-1:0] dout_fold;
  logic           dout_last;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   tog_on;

  logic           prev_stall = 1'b0;
  logic [FW-1:0]  saved_dat;
  logic [4:0]     saved_tag;

  spatial_fold_encoder #(.NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW), .FOLD_WIDTH(FW)) dut (
    .clk           (clk),
    .rst           (rst),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .im_in         (im_in),
    .projm_in      (projm_in),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout          (dout),
    .dout_modality (dout_modality),
    .dout_fold     (dout_fold),
    .dout_last     (dout_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nch(input int m);
    return (m == 0) ? 32 : (m == 1) ? 77 : 105;
  endfunction

  function automatic logic [FW-1:0] rand_vec();
    logic [FW-1:0] v;
    for (int i = 0; i < FW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && dout_valid) begin
        check("stall_dat_stable", dout, saved_dat);
        check("stall_tag_stable", FW'({dout_modality, dout_fold, dout_last}), FW'(saved_tag));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slice: got mod %0d fold %0d with no slice expected",
                   dout_modality, dout_fold);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("slice_dat", dout, e.dat);
          check("slice_tag", FW'({dout_modality, dout_fold, dout_last}), FW'({e.mod, e.fold, e.last}));
        end
      end
      prev_stall = dout_valid && !dout_ready;
      saved_dat  = dout;
      saved_tag  = {dout_modality, dout_fold, dout_last};
      if (prev_stall) check("stall_din_ready_low", FW'(din_ready), FW'(0));
    end
  end

  task automatic send(input logic [FW-1:0] im, input logic [FW-1:0] pm);
    bit ok = 0;
    din_valid = 1'b1;
    im_in     = im;
    projm_in  = pm;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: din_ready stayed 0, required 1 within 2000 cycles");
      din_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // kind 0: im all-1, projm 0 (expect all-1); kind 1: bind bit0 high on the first
  // k beats only (expect expbit at bit0); kind 2: random data, majority model.
  task automatic run_fold(input int kind, input int k, input logic expbit, input int m,
                          input int f, input int max_gap, input bit check_lat, input int limit);
    int            n;
    int            cnt[FW];
    logic [FW-1:0] im, pm, b;
    exp_t          e;
    n = nch(m);
    for (int i = 0; i < FW; i++) cnt[i] = 0;
    for (int beat = 0; beat < n; beat++) begin
      if (limit >= 0 && beat >= limit) return;
      case (kind)
        0: begin im = '1; pm = '0; end
        1: begin im = rand_vec(); pm = im; if (beat < k) im[0] = ~im[0]; end
        default: begin im = rand_vec(); pm = rand_vec(); end
      endcase
      b = im ^ pm;
      for (int i = 0; i < FW; i++) cnt[i] += int'(b[i]);
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      send(im, pm);
    end
    if (check_lat) check("pre_delim_valid", FW'(dout_valid), FW'(0));
    send(rand_vec(), rand_vec());
    if (kind == 0)      e.dat = '1;
    else if (kind == 1) e.dat = {{(FW-1){1'b0}}, expbit};
    else for (int i = 0; i < FW; i++) e.dat[i] = (2 * cnt[i] > n);
    e.mod  = 2'(m);
    e.fold = NFW'(f);
    e.last = (m == 2) && (f == NF - 1);
    exp_q.push_back(e);
    if (check_lat) check("post_delim_valid", FW'(dout_valid), FW'(1));
  endtask

  task automatic run_sample(input int max_gap);
    for (int m = 0; m < 3; m++)
      for (int f = 0; f < NF; f++)
        run_fold(2, 0, 1'b0, m, f, max_gap, 1'b0, -1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check(name, FW'(exp_q.size()), FW'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dout_valid", FW'(dout_valid), FW'(0));
    check("rst_dout", dout, '0);
    check("rst_tags", FW'({dout_modality, dout_fold, dout_last}), FW'(0));
    check("rst_din_ready", FW'(din_ready), FW'(1));
  endtask

  task automatic toggle_ready();
    while (tog_on) begin
      @(posedge clk);
      #1;
      dout_ready = 1'($urandom_range(0, 1));
    end
    dout_ready = 1'b1;
  endtask

  initial begin
    do_reset();

    // Directed thresholds: GSR N=32 (even), ECG N=77, EEG N=105.
    run_fold(0, 0,  1'b0, 0, 0, 0, 1'b1, -1);
    run_fold(1, 16, 1'b0, 0, 1, 0, 1'b0, -1);
    run_fold(1, 17, 1'b1, 0, 2, 0, 1'b0, -1);
    run_fold(2, 0,  1'b0, 0, 3, 0, 1'b0, -1);
    run_fold(1, 38, 1'b0, 1, 0, 0, 1'b0, -1);
    run_fold(1, 39, 1'b1, 1, 1, 0, 1'b0, -1);
    run_fold(2, 0,  1'b0, 1, 2, 0, 1'b0, -1);
    run_fold(2, 0,  1'b0, 1, 3, 0, 1'b0, -1);
    run_fold(1, 52, 1'b0, 2, 0, 0, 1'b0, -1);
    run_fold(1, 53, 1'b1, 2, 1, 0, 1'b0, -1);
    run_fold(0, 0,  1'b0, 2, 2, 0, 1'b0, -1);
    run_fold(2, 0,  1'b0, 2, 3, 0, 1'b0, -1);
    drain("drain_directed");

    // Output held back at the first slice, then released.
    dout_ready = 1'b0;
    fork
      run_sample(0);
      begin repeat (60) @(posedge clk); #1; dout_ready = 1'b1; end
    join
    drain("drain_stall");

    // Random input gaps with random downstream readiness.
    tog_on = 1;
    fork
      begin run_sample(3); tog_on = 0; end
      toggle_ready();
    join
    drain("drain_random");

    // Reset in the middle of ECG fold 2, then a clean restart.
    for (int f = 0; f < NF; f++) run_fold(2, 0, 1'b0, 0, f, 0, 1'b0, -1);
    run_fold(2, 0, 1'b0, 1, 0, 0, 1'b0, -1);
    run_fold(2, 0, 1'b0, 1, 1, 0, 1'b0, -1);
    run_fold(2, 0, 1'b0, 1, 2, 0, 1'b0, 10);
    repeat (3) @(posedge clk);
    #1;
    check("q_empty_pre_rst", FW'(exp_q.size()), FW'(0));
    exp_q.delete();
    do_reset();
    run_sample(1);
    drain("drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
